// File: rtl/machine_timer.sv
// RISC-V machine timer: free-running 64-bit mtime with a prescaler, a shadowed mtimecmp,
// and a level timer-interrupt request. The registers sit behind a 32-bit sel/ack bus.
module machine_timer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic            W,
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            ack,
    output logic            err,
    output logic            time_compare,
    output logic [63:0]     mtime
);

    localparam logic [4:0] AddrMtimeLo = 5'h00;
    localparam logic [4:0] AddrMtimeHi = 5'h04;
    localparam logic [4:0] AddrCmpLo   = 5'h08;
    localparam logic [4:0] AddrCmpHi   = 5'h0C;
    localparam logic [4:0] AddrCtrl    = 5'h10;

    typedef enum logic {StIdle, StResp} state_t;

    state_t                state_q;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [31:0]           cmp_lo_shadow_q;
    logic [31:0]           hi_snapshot_q;
    logic                  enable_q, enable_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  accept, bad_addr, wr, rd, tick;
    logic [XLEN-1:0]       ctrl_rd, rdata_d;

    assign accept   = (state_q == StIdle) && sel;
    assign bad_addr = (addr[1:0] != 2'b00) || (addr > AddrCtrl);
    assign wr       = accept && W && !bad_addr;
    assign rd       = accept && !W && !bad_addr;
    assign tick     = enable_q && (pcnt_q == prescale_q);
    assign mtime    = mtime_q;

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        enable_d   = enable_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        if (enable_q) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                mtime_d = mtime_q + 64'd1;
            end
        end
        // Bus writes override the increment; the lost tick is intentional.
        if (wr) begin
            case (addr)
                AddrMtimeLo: begin
                    mtime_d = {mtime_q[63:32], wdata};
                    pcnt_d  = '0;
                end
                AddrMtimeHi: begin
                    mtime_d = {wdata, mtime_q[31:0]};
                    pcnt_d  = '0;
                end
                AddrCmpHi: mtimecmp_d = {wdata, cmp_lo_shadow_q};
                AddrCtrl: begin
                    enable_d   = wdata[0];
                    prescale_d = wdata[8 +: PRESCALE_W];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ctrl_rd                   = '0;
        ctrl_rd[0]                = enable_q;
        ctrl_rd[8 +: PRESCALE_W]  = prescale_q;
        rdata_d                   = '0;
        if (rd) begin
            case (addr)
                AddrMtimeLo: rdata_d = mtime_q[31:0];
                AddrMtimeHi: rdata_d = hi_snapshot_q;
                AddrCmpLo:   rdata_d = mtimecmp_q[31:0];
                AddrCmpHi:   rdata_d = mtimecmp_q[63:32];
                AddrCtrl:    rdata_d = ctrl_rd;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q         <= '0;
            mtimecmp_q      <= '1;
            cmp_lo_shadow_q <= '1;
            hi_snapshot_q   <= '0;
            enable_q        <= 1'b0;
            prescale_q      <= '0;
            pcnt_q          <= '0;
            time_compare    <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            if (wr && addr == AddrCmpLo) begin
                cmp_lo_shadow_q <= wdata;
            end
            // Latch the upper half so a following hi read pairs with this lo read.
            if (rd && addr == AddrMtimeLo) begin
                hi_snapshot_q <= mtime_q[63:32];
            end
            time_compare <= enable_d && (mtime_d >= mtimecmp_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sel) begin
                        state_q <= StResp;
                        ack     <= !bad_addr;
                        err     <= bad_addr;
                        rdata   <= rdata_d;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: directed scenarios plus random bus traffic checked against a
// closed-form model (mtime = base + elapsed_cycles / (prescale + 1)).
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        W = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, err, time_compare;
    logic [63:0] mtime;

    machine_timer #(.XLEN(32), .PRESCALE_W(8)) dut (
        .clk(clk), .reset(reset), .sel(sel), .W(W), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .time_compare(time_compare), .mtime(mtime)
    );

    always #5 clk = ~clk;

    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: mtime is base at cycle m_ref, then advances once per (m_p + 1) cycles.
    logic [63:0]     m_base, m_cmp;
    logic [31:0]     m_shadow, m_snap;
    logic            m_en;
    logic [7:0]      m_p;
    longint unsigned m_ref;

    // Observed and expected results of the last bus transfer.
    logic [31:0] o_rd, e_rd;
    logic        o_ak, o_er, o_tc, e_ak, e_er, e_tc;
    logic [63:0] o_mt, e_mt;

    function automatic logic [63:0] mt_at(input longint unsigned c);
        if (!m_en) return m_base;
        return m_base + 64'((c - m_ref) / (64'(m_p) + 64'd1));
    endfunction

    function automatic logic tc_at(input longint unsigned c);
        return m_en && (mt_at(c) >= m_cmp);
    endfunction

    task automatic model_reset();
        m_base = '0; m_cmp = '1; m_shadow = '1; m_snap = '0;
        m_en = 1'b0; m_p = '0; m_ref = cyc;
    endtask

    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d);
        longint unsigned e;
        logic [63:0]     pre;
        logic            bad;
        @(negedge clk);
        sel = 1'b1; W = w; addr = a; wdata = d;
        e   = cyc + 1;
        pre = mt_at(cyc);
        bad = (a[1:0] != 2'b00) || (a > 5'h10);
        e_rd = '0; e_ak = !bad; e_er = bad;
        if (!bad && !w) begin
            case (a)
                5'h00: begin e_rd = pre[31:0]; m_snap = pre[63:32]; end
                5'h04: e_rd = m_snap;
                5'h08: e_rd = m_cmp[31:0];
                5'h0C: e_rd = m_cmp[63:32];
                default: e_rd = {16'h0, m_p, 7'h0, m_en};
            endcase
        end else if (!bad) begin
            case (a)
                5'h00: begin m_base = {pre[63:32], d}; m_ref = e; end
                5'h04: begin m_base = {d, pre[31:0]}; m_ref = e; end
                5'h08: m_shadow = d;
                5'h0C: m_cmp = {d, m_shadow};
                default: begin
                    m_base = mt_at(e); m_ref = e; m_en = d[0]; m_p = d[15:8];
                end
            endcase
        end
        @(posedge clk); #1;
        o_rd = rdata; o_ak = ack; o_er = err; o_tc = time_compare; o_mt = mtime;
        e_tc = tc_at(cyc); e_mt = mt_at(cyc);
        sel = 1'b0; W = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (time_compare !== 1'b0 || mtime !== 64'h0 || ack !== 1'b0 || err !== 1'b0 ||
            rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: tc=%b mtime=%h ack=%b err=%b rdata=%h want all 0",
                     time_compare, mtime, ack, err, rdata);
        end
        bus(1'b0, 5'h08, 32'h0);
        n_cmp++;
        if (o_ak !== 1'b1 || o_rd !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL reset_cmp_lo: ack=%b rdata=%h want 1 ffffffff", o_ak, o_rd);
        end
        bus(1'b0, 5'h0C, 32'h0);
        n_cmp++;
        if (o_ak !== 1'b1 || o_rd !== 32'hFFFF_FFFF || o_tc !== 1'b0 || o_mt !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_cmp_hi: ack=%b rdata=%h tc=%b mtime=%h want 1 ffffffff 0 0",
                     o_ak, o_rd, o_tc, o_mt);
        end
    endtask

    task automatic test_count();
        bus(1'b1, 5'h08, 32'd20);
        bus(1'b1, 5'h0C, 32'd0);
        bus(1'b1, 5'h10, 32'h0000_0001);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mtime !== mt_at(cyc) || time_compare !== (mtime >= 64'd20)) begin
                n_bad++;
                $display("FAIL count_cmp: mtime=%0d tc=%b want mtime=%0d tc=%b",
                         mtime, time_compare, mt_at(cyc), mt_at(cyc) >= 64'd20);
            end
        end
    endtask

    task automatic test_prescale();
        logic [63:0] start, delta;
        bus(1'b1, 5'h10, 32'h0000_0301);
        start = mtime;
        repeat (40) @(posedge clk);
        #1;
        delta = mtime - start;
        n_cmp++;
        if (delta < 64'd9 || delta > 64'd11 || mtime !== mt_at(cyc)) begin
            n_bad++;
            $display("FAIL prescale_delta: delta=%0d mtime=%0d want 10+-1 mtime=%0d",
                     delta, mtime, mt_at(cyc));
        end
    endtask

    task automatic test_carry();
        bus(1'b1, 5'h10, 32'h0);
        bus(1'b1, 5'h00, 32'hFFFF_FFFE);
        bus(1'b1, 5'h04, 32'h0);
        bus(1'b1, 5'h10, 32'h0000_0001);
        @(posedge clk); #1;
        n_cmp++;
        if (mtime !== 64'h1_0000_0000) begin
            n_bad++;
            $display("FAIL carry_mtime: mtime=%h want 0000000100000000", mtime);
        end
        bus(1'b0, 5'h00, 32'h0);
        n_cmp++;
        if (o_rd !== 32'h0 || o_rd !== e_rd) begin
            n_bad++;
            $display("FAIL carry_lo_read: rdata=%h want 00000000", o_rd);
        end
        bus(1'b1, 5'h04, 32'h0000_0007);
        bus(1'b0, 5'h04, 32'h0);
        n_cmp++;
        if (o_rd !== 32'h1 || o_rd !== e_rd) begin
            n_bad++;
            $display("FAIL carry_hi_snapshot: rdata=%h want 00000001", o_rd);
        end
    endtask

    task automatic test_commit();
        bus(1'b1, 5'h10, 32'h0);
        bus(1'b1, 5'h00, 32'd100);
        bus(1'b1, 5'h04, 32'd0);
        bus(1'b1, 5'h08, 32'd20);
        bus(1'b1, 5'h0C, 32'd0);
        bus(1'b1, 5'h10, 32'h0000_FF01);
        n_cmp++;
        if (time_compare !== 1'b1 || mtime !== 64'd100) begin
            n_bad++;
            $display("FAIL commit_setup: tc=%b mtime=%0d want 1 100", time_compare, mtime);
        end
        bus(1'b1, 5'h08, 32'd500);
        n_cmp++;
        if (o_tc !== 1'b1 || time_compare !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_lo_no_effect: tc=%b/%b want 1", o_tc, time_compare);
        end
        bus(1'b1, 5'h0C, 32'd0);
        n_cmp++;
        if (o_tc !== 1'b0 || o_ak !== 1'b1 || o_tc !== e_tc) begin
            n_bad++;
            $display("FAIL commit_hi_drop: tc=%b ack=%b want 0 1", o_tc, o_ak);
        end
    endtask

    task automatic test_err();
        logic [4:0] bad_addrs [3];
        bad_addrs[0] = 5'h02; bad_addrs[1] = 5'h14; bad_addrs[2] = 5'h1D;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 2; w++) begin
                bus(1'(w), bad_addrs[i], $urandom);
                n_cmp++;
                if (o_er !== 1'b1 || o_ak !== 1'b0 || o_rd !== 32'h0) begin
                    n_bad++;
                    $display("FAIL err_addr_%h: err=%b ack=%b rdata=%h want 1 0 0",
                             bad_addrs[i], o_er, o_ak, o_rd);
                end
            end
        end
        bus(1'b0, 5'h10, 32'h0);
        n_cmp++;
        if (o_rd !== 32'h0000_FF01) begin
            n_bad++;
            $display("FAIL err_ctrl_intact: rdata=%h want 0000ff01", o_rd);
        end
        bus(1'b0, 5'h08, 32'h0);
        n_cmp++;
        if (o_rd !== 32'd500) begin
            n_bad++;
            $display("FAIL err_cmp_intact: rdata=%h want 000001f4", o_rd);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sel = 1'b1; W = 1'b0; addr = 5'h10; wdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== (i % 2 == 0) || rdata !== ((i % 2 == 0) ? 32'h0000_FF01 : 32'h0)) begin
                n_bad++;
                $display("FAIL back_to_back_%0d: ack=%b rdata=%h want %b", i, ack, rdata,
                         i % 2 == 0);
            end
        end
        @(negedge clk);
        sel = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        sel = 1'b1; W = 1'b1; addr = 5'h00; wdata = 32'h1234;
        @(posedge clk); #1;
        reset = 1'b1; sel = 1'b0; W = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || time_compare !== 1'b0 ||
                mtime !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_in_resp_%0d: ack=%b err=%b rdata=%h tc=%b mtime=%h", i,
                         ack, err, rdata, time_compare, mtime);
            end
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        bus(1'b0, 5'h10, 32'h0);
        n_cmp++;
        if (o_rd !== 32'h0 || o_ak !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_resp_ctrl: rdata=%h ack=%b want 0 1", o_rd, o_ak);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd_addrs [5];
        rd_addrs[0] = 5'h00; rd_addrs[1] = 5'h04; rd_addrs[2] = 5'h08;
        rd_addrs[3] = 5'h0C; rd_addrs[4] = 5'h10;
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1: bus(1'b0, rd_addrs[$urandom_range(0, 4)], 32'h0);
                2: bus(1'b1, 5'h00, $urandom);
                3: bus(1'b1, 5'h04, $urandom_range(0, 1));
                4: bus(1'b1, 5'h08, $urandom);
                5: bus(1'b1, 5'h0C, $urandom_range(0, 1));
                6: bus(1'b1, 5'h10, {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom)});
                7: bus(1'($urandom), 5'($urandom_range(17, 31)), $urandom);
                8: begin
                    bus(1'b1, 5'h04, 32'hFFFF_FFFF);
                    bus(1'b1, 5'h00, 32'hFFFF_FFF0 + $urandom_range(0, 15));
                end
                default: begin
                    for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
                        @(posedge clk); #1;
                        n_cmp++;
                        if (mtime !== mt_at(cyc) || time_compare !== tc_at(cyc)) begin
                            n_bad++;
                            $display("FAIL rand_idle: mtime=%h tc=%b want %h %b", mtime,
                                     time_compare, mt_at(cyc), tc_at(cyc));
                        end
                    end
                    e_rd = o_rd; e_ak = o_ak; e_er = o_er; e_tc = o_tc; e_mt = o_mt;
                end
            endcase
            n_cmp++;
            if (o_rd !== e_rd || o_ak !== e_ak || o_er !== e_er || o_tc !== e_tc ||
                o_mt !== e_mt) begin
                n_bad++;
                $display("FAIL rand_xfer_%0d: rd=%h ack=%b err=%b tc=%b mt=%h want %h %b %b %b %h",
                         n, o_rd, o_ak, o_er, o_tc, o_mt, e_rd, e_ak, e_er, e_tc, e_mt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_prescale();
        test_carry();
        test_commit();
        test_err();
        test_back_to_back();
        test_reset_in_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
